// File: rtl/e16_arb_pkg.sv
// Shared types, default widths and pointer helper for the e16 round-robin burst arbiter.
// Pure declarations: no logic, no latency, no backpressure.
package e16_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_t;

  localparam int ARB_N_DEF   = 4;
  localparam int ARB_BLW_DEF = 4;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1) % n;
  endfunction

endpackage

// File: rtl/e16_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping N-1 -> 0.
// Zero latency; no backpressure, purely a function of request and ptr.
module e16_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] index,
  output logic          valid
);

  logic [2*N-1:0] rot_dbl;
  logic [N-1:0]   rot_req;
  logic [N-1:0]   fix_oh;
  logic [IW-1:0]  fix_idx;
  logic           found;
  logic [2*N-1:0] back_dbl;
  logic [IW:0]    idx_sum;

  // Rotate so that requester ptr lands on bit 0, then lowest-bit-wins.
  assign rot_dbl = {request, request} >> ptr;
  assign rot_req = rot_dbl[N-1:0];

  always_comb begin
    fix_oh  = '0;
    fix_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot_req[i]) begin
        found     = 1'b1;
        fix_oh[i] = 1'b1;
        fix_idx   = IW'(i);
      end
    end
  end

  assign back_dbl = {fix_oh, fix_oh} << ptr;
  assign pick     = back_dbl[2*N-1:N];

  assign idx_sum = {1'b0, fix_idx} + {1'b0, ptr};
  assign index   = (idx_sum >= (IW+1)'(N)) ? IW'(idx_sum - (IW+1)'(N)) : IW'(idx_sum);
  assign valid   = found;

endmodule

// File: rtl/e16_arbiter_rr_burst.sv
// Round-robin arbiter that locks the channel to one requester for a whole burst of req_len+1 beats.
// Grant one cycle after a request is seen in IDLE; out_wait or a dropped request stalls the burst, one IDLE bubble per burst.
module e16_arbiter_rr_burst
  import e16_arb_pkg::*;
#(
  parameter int N   = ARB_N_DEF,
  parameter int BLW = ARB_BLW_DEF,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           clk_en,
  input  logic [N-1:0]   request,
  input  logic [N*BLW-1:0] req_len,
  input  logic           out_wait,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   arb_wait,
  output logic           busy,
  output logic [IW-1:0]  owner
);

  arb_state_t     state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [BLW-1:0] beat_cnt_q, beat_cnt_d;

  logic [N-1:0]   pick_oh;
  logic [IW-1:0]  pick_idx;
  logic           pick_vld;
  logic [BLW-1:0] win_len;
  logic           accept;

  e16_rr_pick #(.N(N), .IW(IW)) u_pick (
    .request (request),
    .ptr     (rr_ptr_q),
    .pick    (pick_oh),
    .index   (pick_idx),
    .valid   (pick_vld)
  );

  assign win_len = req_len[int'(pick_idx)*BLW +: BLW];
  assign accept  = (state_q == ARB_XFER) & clk_en & request[owner_q] & ~out_wait;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (clk_en && pick_vld) begin
          state_d    = ARB_XFER;
          grant_d    = pick_oh;
          owner_d    = pick_idx;
          beat_cnt_d = win_len;
        end
      end
      ARB_XFER: begin
        if (accept) begin
          if (beat_cnt_q == '0) begin
            // Pointer moves only on burst completion, which bounds starvation to N-1 bursts.
            state_d  = ARB_IDLE;
            grant_d  = '0;
            rr_ptr_d = IW'(rr_next(int'(owner_q), N));
          end else begin
            beat_cnt_d = beat_cnt_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant    = grant_q;
  assign busy     = (state_q == ARB_XFER);
  assign owner    = owner_q;
  assign arb_wait = request & ~(grant_q & ~{N{out_wait}});

endmodule

// File: tb/tb_e16_arbiter_rr_burst.sv
// Bench for e16_arbiter_rr_burst: directed bring-up and rotation, then random traffic against a burst-level model.
module tb_e16_arbiter_rr_burst;

  localparam int N   = 4;
  localparam int BLW = 4;
  localparam int IW  = 2;

  logic           clk = 1'b0;
  logic           nreset;
  logic           clk_en;
  logic [N-1:0]   request;
  logic [N*BLW-1:0] req_len;
  logic           out_wait;
  logic [N-1:0]   grant;
  logic [N-1:0]   arb_wait;
  logic           busy;
  logic [IW-1:0]  owner;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who holds the channel, how many beats remain, whose turn is next.
  int m_holder = -1;
  int m_left   = 0;
  int m_next   = 0;
  int m_last   = 0;

  logic [N-1:0] obs_grant;
  int dut_beats;

  e16_arbiter_rr_burst #(.N(N), .BLW(BLW)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .clk_en   (clk_en),
    .request  (request),
    .req_len  (req_len),
    .out_wait (out_wait),
    .grant    (grant),
    .arb_wait (arb_wait),
    .busy     (busy),
    .owner    (owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int len_of(input logic [N*BLW-1:0] lens, input int i);
    logic [BLW-1:0] l;
    l = lens[i*BLW +: BLW];
    return int'(l);
  endfunction

  task automatic model_edge(input logic [N-1:0] rq, input logic [N*BLW-1:0] ln,
                            input logic ow, input logic ce, input logic nr);
    if (!nr) begin
      m_holder = -1; m_left = 0; m_next = 0; m_last = 0;
    end else if (ce) begin
      if (m_holder < 0) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_next + k) % N;
          if (rq[c]) begin
            m_holder = c;
            m_last   = c;
            m_left   = len_of(ln, c) + 1;
            break;
          end
        end
      end else if (rq[m_holder] && !ow) begin
        m_left--;
        if (m_left == 0) begin
          m_next   = (m_holder + 1) % N;
          m_holder = -1;
        end
      end
    end
  endtask

  // Called at the falling edge: apply inputs, check, then advance through one rising edge.
  task automatic step(input logic [N-1:0] rq, input logic [N*BLW-1:0] ln,
                      input logic ow, input logic ce, input logic nr);
    logic [N-1:0] exp_g;
    request = rq; req_len = ln; out_wait = ow; clk_en = ce; nreset = nr;
    #1;
    exp_g = (m_holder < 0) ? '0 : N'(1 << m_holder);
    chk("grant", 32'(grant), 32'(exp_g));
    chk("busy", 32'(busy), 32'(m_holder >= 0));
    chk("owner", 32'(owner), 32'(m_last));
    chk("arb_wait", 32'(arb_wait), 32'(rq & ~(exp_g & ~{N{ow}})));
    obs_grant = grant;
    if (|(grant & rq) && !ow && ce && nr) dut_beats++;
    @(posedge clk);
    model_edge(rq, ln, ow, ce, nr);
    @(negedge clk);
  endtask

  logic [N-1:0] rot_exp [10];

  initial begin
    rot_exp = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000,
                4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    nreset = 1'b0; clk_en = 1'b1; request = '0; req_len = '0; out_wait = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Single requester, 3-beat burst.
    step('0, '0, 1'b0, 1'b1, 1'b0);
    dut_beats = 0;
    for (int i = 0; i < 5; i++) step(4'b0001, 16'h0002, 1'b0, 1'b1, 1'b1);
    chk("single_beats", 32'(dut_beats), 32'd3);
    step('0, '0, 1'b0, 1'b1, 1'b1);

    // Rotation from a fresh reset, single-beat bursts.
    step('0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(4'b1111, '0, 1'b0, 1'b1, 1'b1);
      chk($sformatf("rot%0d", i), 32'(obs_grant), 32'(rot_exp[i]));
    end

    // Owner 2 with a stalled 4-beat burst.
    step('0, '0, 1'b0, 1'b1, 1'b0);
    dut_beats = 0;
    step(4'b0100, 16'h0300, 1'b0, 1'b1, 1'b1);
    step(4'b0100, 16'h0300, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0100, 16'h0300, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b0100, 16'h0300, 1'b0, 1'b1, 1'b1);
    chk("stall_beats", 32'(dut_beats), 32'd4);

    // clk_en freeze mid-burst, then reset mid-burst.
    step('0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0010, 16'h0070, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(4'b1111, 16'h0070, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0010, 16'h0070, 1'b0, 1'b1, 1'b1);
    step(4'b1010, 16'h0070, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b1111, '0, 1'b0, 1'b1, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] rq;
      logic [N*BLW-1:0] ln;
      for (int b = 0; b < N; b++) rq[b] = ($urandom_range(99, 0) < 65);
      ln = N*BLW'($urandom);
      if ($urandom_range(1, 0) == 1) ln = ln & {N{4'b0011}};
      step(rq, ln, $urandom_range(99, 0) < 25, $urandom_range(99, 0) < 90,
           $urandom_range(299, 0) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
